// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_DATA_W-1:0] inst_bus_t;

  localparam inst_bus_t ZERO_WORD  = 32'h0000_0000;
  localparam inst_bus_t NOP_INST   = 32'h0000_0000;
  localparam logic      RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  // A memory request is outstanding in every state except IDLE.
  function automatic logic req_active(input fetch_state_e s);
    return (s == ST_REQ) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, inst} pairs.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  fetch_fifo_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (push_i),
    .pop_i   (pop_i),
    .count_i (count_q)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Overflow checker for the prefetch FIFO.
module fetch_fifo_chk
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             clear_i,
  input logic             push_i,
  input logic             pop_i,
  input logic [CNT_W-1:0] count_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
    !(push_i && !pop_i && !clear_i && (count_i == CNT_W'(DEPTH))));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding imem request FSM and prefetch FIFO
// with flush/redirect handling.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned FIFO_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              push_s, pop_s, valid_s, room_s;
  logic [CNT_W-1:0]  count_s, next_count_s;
  logic [FIFO_W-1:0] head_s;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  ({pc_q, imem_rdata_i}),
    .count_o (count_s),
    .head_o  (head_s)
  );

  always_comb begin
    valid_s      = (count_s != '0) && !flush_i;
    push_s       = (state_q == ST_REQ) && imem_ack_i && !flush_i;
    pop_s        = valid_s && !stall_i;
    next_count_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    room_s       = next_count_s < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      addr_q  <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // In DROP the bus keeps the abandoned address until its ack; pc already holds the target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (flush_i) begin
      pc_d = new_pc_i & ALIGN_MASK;
      if (req_active(state_q) && !imem_ack_i) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (room_s) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (imem_ack_i) begin
            pc_d = pc_q + PC_STEP;
            if (room_s) begin
              state_d = ST_REQ;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_ack_i) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if (state_d == ST_DROP) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  always_comb begin
    imem_req_o  = req_active(state_q);
    imem_addr_o = addr_q;
    if_valid_o  = valid_s;
    if (valid_s) begin
      if_pc_o   = head_s[FIFO_W-1:INST_W];
      if_inst_o = head_s[INST_W-1:0];
    end else begin
      if_pc_o   = ADDR_W'(ZERO_WORD);
      if_inst_o = INST_W'(NOP_INST);
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a variable-latency memory model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int checks = 0;
  int fails  = 0;
  int unsigned mem_wait = 0;
  int unsigned wait_cnt = 0;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .ADDR_W   (32),
    .INST_W   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .new_pc_i     (new_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_valid_o   (if_valid_o)
  );

  always #5 clk = ~clk;

  // Memory: acks after mem_wait idle cycles of a held request; tolerates withdrawn requests.
  always @(posedge clk) begin
    if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack_i   = imem_req_o && (wait_cnt >= mem_wait);
  assign imem_rdata_i = imem_addr_o ^ XOR_KEY;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'h0; mem_wait = 0;
    cyc(); cyc(); cyc();
    checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 00000000", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 00000000", if_inst_o); end
  endtask

  task automatic test_zero_wait();
    mem_wait = 0; stall_i = 1'b0;
    do_reset();
    cyc();
    checks++; if (imem_req_o !== 1'b1) begin fails++; $display("FAIL zw_first_req: got %b expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL zw_first_addr: got %h expected 00000000", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL zw_first_valid: got %b expected 0", if_valid_o); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (if_valid_o !== 1'b1) begin fails++; $display("FAIL zw_valid[%0d]: got %b expected 1", i, if_valid_o); end
      checks++; if (if_pc_o !== 32'(i * 4)) begin fails++; $display("FAIL zw_pc[%0d]: got %h expected %h", i, if_pc_o, 32'(i * 4)); end
      checks++; if (if_inst_o !== (32'(i * 4) ^ XOR_KEY)) begin fails++; $display("FAIL zw_inst[%0d]: got %h expected %h", i, if_inst_o, 32'(i * 4) ^ XOR_KEY); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_pc, prev_addr;
    logic        prev_hold;
    int          n, last_c;
    mem_wait = 2; stall_i = 1'b0;
    exp_pc = 32'h0; prev_addr = 32'h0; prev_hold = 1'b0; n = 0; last_c = 0;
    do_reset();
    for (int c = 0; c < 40 && n < 4; c++) begin
      cyc();
      if (prev_hold) begin
        checks++; if (imem_addr_o !== prev_addr) begin fails++; $display("FAIL lat_addr_stable: got %h expected %h", imem_addr_o, prev_addr); end
      end
      prev_hold = imem_req_o && !imem_ack_i;
      prev_addr = imem_addr_o;
      if (if_valid_o) begin
        checks++; if (if_pc_o !== exp_pc) begin fails++; $display("FAIL lat_pc: got %h expected %h", if_pc_o, exp_pc); end
        checks++; if (if_inst_o !== (exp_pc ^ XOR_KEY)) begin fails++; $display("FAIL lat_inst: got %h expected %h", if_inst_o, exp_pc ^ XOR_KEY); end
        if (n > 0) begin
          checks++; if (c - last_c != 3) begin fails++; $display("FAIL lat_gap: got %0d expected 3", c - last_c); end
        end
        last_c = c;
        n++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (n != 4) begin fails++; $display("FAIL lat_count: got %0d expected 4", n); end
  endtask

  task automatic test_stall();
    mem_wait = 0; stall_i = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) cyc();
    checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL stall_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h8) begin fails++; $display("FAIL stall_addr: got %h expected 00000008", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b expected 1", if_valid_o); end
    stall_i = 1'b0;
    #1;
    checks++; if (if_pc_o !== 32'h0) begin fails++; $display("FAIL stall_head: got %h expected 00000000", if_pc_o); end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++; if (if_valid_o !== 1'b1) begin fails++; $display("FAIL stall_rel_valid[%0d]: got %b expected 1", k, if_valid_o); end
      checks++; if (if_pc_o !== 32'(k * 4)) begin fails++; $display("FAIL stall_rel_pc[%0d]: got %h expected %h", k, if_pc_o, 32'(k * 4)); end
    end
  endtask

  task automatic test_flush_outstanding();
    logic found, seen_new, got_valid;
    mem_wait = 2; stall_i = 1'b0; found = 1'b0; seen_new = 1'b0; got_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 60 && !found; c++) begin
      cyc();
      if (imem_req_o && imem_addr_o == 32'h10) found = 1'b1;
    end
    checks++; if (!found) begin fails++; $display("FAIL fl_find_req10: got 0 expected 1"); end
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC) begin fails++; $display("FAIL fl_pre_valid: got %b/%h expected 1/0000000c", if_valid_o, if_pc_o); end
    flush_i = 1'b1; new_pc_i = 32'h0000_0103;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL fl_cycle_valid: got %b expected 0", if_valid_o); end
    cyc();
    flush_i = 1'b0; new_pc_i = 32'h0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin fails++; $display("FAIL fl_drop_addr: got %b/%h expected 1/00000010", imem_req_o, imem_addr_o); end
    for (int c = 0; c < 20 && !got_valid; c++) begin
      cyc();
      if (imem_req_o && imem_addr_o != 32'h10 && !seen_new) begin
        seen_new = 1'b1;
        checks++; if (imem_addr_o !== 32'h100) begin fails++; $display("FAIL fl_new_addr: got %h expected 00000100", imem_addr_o); end
      end
      if (if_valid_o) begin
        got_valid = 1'b1;
        checks++; if (if_pc_o !== 32'h100) begin fails++; $display("FAIL fl_first_pc: got %h expected 00000100", if_pc_o); end
        checks++; if (if_inst_o !== (32'h100 ^ XOR_KEY)) begin fails++; $display("FAIL fl_first_inst: got %h expected %h", if_inst_o, 32'h100 ^ XOR_KEY); end
      end
    end
    checks++; if (!got_valid) begin fails++; $display("FAIL fl_timeout: got 0 expected 1"); end
  endtask

  task automatic test_flush_on_ack();
    logic found, got_valid;
    mem_wait = 2; stall_i = 1'b1; found = 1'b0; got_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (imem_req_o && imem_ack_i && imem_addr_o == 32'h4) found = 1'b1;
    end
    checks++; if (!found) begin fails++; $display("FAIL fa_find_ack4: got 0 expected 1"); end
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin fails++; $display("FAIL fa_pre_head: got %b/%h expected 1/00000000", if_valid_o, if_pc_o); end
    flush_i = 1'b1; new_pc_i = 32'h0000_0200;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL fa_cycle_valid: got %b expected 0", if_valid_o); end
    cyc();
    flush_i = 1'b0; new_pc_i = 32'h0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin fails++; $display("FAIL fa_new_req: got %b/%h expected 1/00000200", imem_req_o, imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL fa_cleared: got %b expected 0", if_valid_o); end
    stall_i = 1'b0;
    for (int c = 0; c < 20 && !got_valid; c++) begin
      cyc();
      if (if_valid_o) begin
        got_valid = 1'b1;
        checks++; if (if_pc_o !== 32'h200) begin fails++; $display("FAIL fa_first_pc: got %h expected 00000200", if_pc_o); end
      end
    end
    checks++; if (!got_valid) begin fails++; $display("FAIL fa_timeout: got 0 expected 1"); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    mem_wait = 0; stall_i = 1'b0;
    do_reset();
    cyc();
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFF8;
    cyc();
    flush_i = 1'b0; new_pc_i = 32'h0;
    checks++; if (imem_addr_o !== 32'hFFFF_FFF8 || if_valid_o !== 1'b0) begin fails++; $display("FAIL wrap_req: got %h/%b expected fffffff8/0", imem_addr_o, if_valid_o); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc[i]) begin fails++; $display("FAIL wrap_pc[%0d]: got %b/%h expected 1/%h", i, if_valid_o, if_pc_o, exp_pc[i]); end
      checks++; if (if_inst_o !== (exp_pc[i] ^ XOR_KEY)) begin fails++; $display("FAIL wrap_inst[%0d]: got %h expected %h", i, if_inst_o, exp_pc[i] ^ XOR_KEY); end
    end
    mem_wait = 3;
    #1;
    checks++; if (imem_req_o !== 1'b1) begin fails++; $display("FAIL mid_req_pending: got %b expected 1", imem_req_o); end
    rst = 1'b0;
    cyc();
    checks++; if (imem_req_o !== 1'b0) begin fails++; $display("FAIL mid_rst_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin fails++; $display("FAIL mid_rst_addr: got %h expected 00000000", imem_addr_o); end
    checks++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin fails++; $display("FAIL mid_rst_pc: got %h expected 00000000", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin fails++; $display("FAIL mid_rst_inst: got %h expected 00000000", if_inst_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_flush_outstanding();
    test_flush_on_ack();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
